// File: rtl/spi2dac_pkg.sv
// spi2dac_pkg: FSM states and MCP4911 write-frame layout shared by the SPI transmitter
package spi2dac_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LDAC} state_t;
    localparam int FRAME_BITS = 16;
    localparam int BUF_BIT = 14;
    localparam int GA_BIT = 13;
    localparam int SHDN_BIT = 12;
    localparam int DATA_LSB = 2;
    localparam int DATA_BITS = 10;

    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic buf_en,
        input logic ga_n,
        input logic shdn_n,
        input logic [DATA_BITS-1:0] data
    );
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[BUF_BIT] = buf_en;
        f[GA_BIT] = ga_n;
        f[SHDN_BIT] = shdn_n;
        f[DATA_LSB +: DATA_BITS] = data;
        return f;
    endfunction
endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: SCK half-period divider, counter held at zero while disabled
module spi_tick_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic sysclk,
    input  logic reset,
    input  logic enable,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);
    logic [CW-1:0] cnt;
    assign tick = enable && (cnt == CW'(CLK_DIV - 1));
    always_ff @(posedge sysclk) begin
        if (reset || !enable || tick) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/spi2dac_tx.sv
// spi2dac_tx: serialises 10-bit samples into MCP4911 SPI frames with a 1-deep pending buffer
module spi2dac_tx
    import spi2dac_pkg::*;
#(
    parameter int CLK_DIV     = 25,
    parameter bit BUF         = 1'b1,
    parameter bit GA_N        = 1'b1,
    parameter bit SHDN_N      = 1'b1,
    parameter int LDAC_CYCLES = 2
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 load,
    output logic                 busy,
    output logic                 overrun,
    output logic                 dac_cs_n,
    output logic                 dac_sck,
    output logic                 dac_sdi,
    output logic                 dac_ld_n
);
    localparam int BW = $clog2(FRAME_BITS);
    localparam int LW = $clog2(LDAC_CYCLES + 1);
    state_t state_q, state_d;
    logic [FRAME_BITS-1:0] sreg_q, sreg_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [LW-1:0] lc_q, lc_d;
    logic [DATA_BITS-1:0] pend_q, pend_d;
    logic pend_v_q, pend_v_d, sck_d, ovr_d, tick, frame_d;

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .sysclk(sysclk),
        .reset (reset),
        .enable(state_q inside {SETUP, SHIFT, HOLD}),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        sreg_d = sreg_q;
        bit_d = bit_q;
        lc_d = lc_q;
        sck_d = dac_sck;
        pend_d = pend_q;
        pend_v_d = pend_v_q;
        ovr_d = 1'b0;
        case (state_q)
            IDLE: if (load || pend_v_q) begin
                sreg_d = make_frame(BUF, GA_N, SHDN_N, load ? data_in : pend_q);
                bit_d = '0;
                sck_d = 1'b0;
                pend_v_d = 1'b0;
                ovr_d = load && pend_v_q;
                state_d = SETUP;
            end
            SETUP: if (tick) state_d = SHIFT;
            SHIFT: if (tick) begin
                sck_d = !dac_sck;
                if (dac_sck) begin
                    sreg_d = sreg_q << 1;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == BW'(FRAME_BITS - 1)) state_d = HOLD;
                end
            end
            HOLD: if (tick) begin
                lc_d = '0;
                state_d = LDAC;
            end
            LDAC: if (lc_q == LW'(LDAC_CYCLES)) state_d = IDLE;
                  else lc_d = lc_q + 1'b1;
            default: state_d = IDLE;
        endcase
        if (load && state_q != IDLE) begin
            pend_d = data_in;
            pend_v_d = 1'b1;
            ovr_d = pend_v_q;
        end
        frame_d = state_d inside {SETUP, SHIFT, HOLD};
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q <= '0;
            bit_q <= '0;
            lc_q <= '0;
            pend_q <= '0;
            pend_v_q <= 1'b0;
            dac_cs_n <= 1'b1;
            dac_sck <= 1'b0;
            dac_sdi <= 1'b0;
            dac_ld_n <= 1'b1;
            busy <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q <= sreg_d;
            bit_q <= bit_d;
            lc_q <= lc_d;
            pend_q <= pend_d;
            pend_v_q <= pend_v_d;
            dac_cs_n <= !frame_d;
            dac_sck <= sck_d;
            dac_sdi <= frame_d && sreg_d[FRAME_BITS-1];
            dac_ld_n <= !(state_d == LDAC && lc_d != '0);
            busy <= state_d != IDLE;
            overrun <= ovr_d;
        end
    end
endmodule

// File: tb/tb_spi2dac_tx.sv
// tb_spi2dac_tx: scoreboard bench, one model SPI slave per DUT (BUF=1 and BUF=0)
module tb_spi2dac_tx;
    logic sysclk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] load = '0;
    logic [9:0] din [2];
    logic [1:0] busy, overrun, cs_n, sck, sdi, ld_n;
    int passed = 0;
    int total = 0;

    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        spi2dac_tx #(
            .CLK_DIV(2), .BUF(g == 0), .GA_N(1'b1), .SHDN_N(1'b1), .LDAC_CYCLES(2)
        ) u_dut (
            .sysclk  (sysclk),
            .reset   (reset),
            .data_in (din[g]),
            .load    (load[g]),
            .busy    (busy[g]),
            .overrun (overrun[g]),
            .dac_cs_n(cs_n[g]),
            .dac_sck (sck[g]),
            .dac_sdi (sdi[g]),
            .dac_ld_n(ld_n[g])
        );
        logic [15:0] exp_q[$];
        logic [15:0] sh = '0;
        int rises = 0, cs_len = 0, ld_len = 0, busy_len = 0, ov_cnt = 0;
        logic bad = 1'b0, p_cs = 1'b1, p_sck = 1'b0, p_sdi = 1'b0, p_ld = 1'b1, p_busy = 1'b0;

        always @(negedge sysclk) begin
            if (reset) begin
                rises = 0; cs_len = 0; ld_len = 0; busy_len = 0; bad = 1'b0; sh = '0;
                p_cs = 1'b1; p_sck = 1'b0; p_sdi = 1'b0; p_ld = 1'b1; p_busy = 1'b0;
            end else begin
                if (!cs_n[g]) begin
                    cs_len++;
                    if (sck[g] && sdi[g] != p_sdi) bad = 1'b1;
                    if (sck[g] && !p_sck) begin
                        sh = {sh[14:0], sdi[g]};
                        rises++;
                    end
                end else if (sck[g]) bad = 1'b1;
                if (cs_n[g] && !p_cs) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL dut%0d_unexpected_frame: got 0x%0h, want no frame", g, sh);
                    end else begin
                        chk($sformatf("dut%0d_frame", g), int'(sh), int'(exp_q.pop_front()));
                        chk($sformatf("dut%0d_sck_rises", g), rises, 16);
                        chk($sformatf("dut%0d_cs_low_cycles", g), cs_len, 68);
                        chk($sformatf("dut%0d_sck_sdi_timing", g), int'(bad), 0);
                    end
                    rises = 0; cs_len = 0; bad = 1'b0;
                end
                if (!ld_n[g]) ld_len++;
                else if (!p_ld) begin
                    chk($sformatf("dut%0d_ld_low_cycles", g), ld_len, 2);
                    ld_len = 0;
                end
                if (busy[g]) busy_len++;
                else if (p_busy) begin
                    chk($sformatf("dut%0d_busy_cycles", g), busy_len, 71);
                    busy_len = 0;
                end
                if (overrun[g]) ov_cnt++;
                p_cs = cs_n[g]; p_sck = sck[g]; p_sdi = sdi[g]; p_ld = ld_n[g]; p_busy = busy[g];
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send(input int g, input logic [9:0] d, input bit want);
        logic [15:0] f;
        f = {1'b0, g == 0, 2'b11, d, 2'b00};
        if (want) begin
            if (g == 0) gi[0].exp_q.push_back(f);
            else gi[1].exp_q.push_back(f);
        end
        din[g] = d;
        load[g] = 1'b1;
        step(1);
        load[g] = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((gi[0].exp_q.size() != 0 || gi[1].exp_q.size() != 0 || busy != 2'b00) && n < 2000) begin
            step(1);
            n++;
        end
        chk(name, int'(n < 2000), 1);
        step(3);
    endtask

    initial begin
        int ov0, lows, n;
        din[0] = '0;
        din[1] = '0;
        step(3);
        chk("rst_cs_n", int'(cs_n), 3);
        chk("rst_sck", int'(sck), 0);
        chk("rst_sdi", int'(sdi), 0);
        chk("rst_ld_n", int'(ld_n), 3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset = 1'b0;
        step(2);

        send(0, 10'h3FF, 1'b1);
        chk("t1_cs_latency", int'(cs_n[0]), 0);
        chk("t1_busy_rise", int'(busy[0]), 1);
        wait_done("t1_done");

        send(1, 10'h200, 1'b1);
        wait_done("t2_done");

        ov0 = gi[0].ov_cnt;
        send(0, 10'h001, 1'b1);
        step(20);
        send(0, 10'h155, 1'b1);
        wait_done("t3_done");
        chk("t3_overrun_count", gi[0].ov_cnt - ov0, 0);

        ov0 = gi[0].ov_cnt;
        send(0, 10'h0AA, 1'b1);
        step(10);
        send(0, 10'h111, 1'b0);
        chk("t4_no_overrun_second", int'(overrun[0]), 0);
        step(10);
        send(0, 10'h222, 1'b1);
        chk("t4_overrun_pulse", int'(overrun[0]), 1);
        step(1);
        chk("t4_overrun_one_cycle", int'(overrun[0]), 0);
        wait_done("t4_done");
        chk("t4_overrun_count", gi[0].ov_cnt - ov0, 1);

        send(0, 10'h3A5, 1'b0);
        step(10);
        send(0, 10'h05A, 1'b0);
        step(20);
        reset = 1'b1;
        step(1);
        chk("t5_cs_n", int'(cs_n[0]), 1);
        chk("t5_sck", int'(sck[0]), 0);
        chk("t5_sdi", int'(sdi[0]), 0);
        chk("t5_busy", int'(busy[0]), 0);
        reset = 1'b0;
        lows = 0;
        repeat (150) begin
            step(1);
            if (!cs_n[0] || !ld_n[0] || busy[0]) lows++;
        end
        chk("t5_quiet_after_reset", lows, 0);
        send(0, 10'h2C3, 1'b1);
        wait_done("t5_clean_frame");

        ov0 = gi[0].ov_cnt;
        send(0, 10'h123, 1'b1);
        n = 0;
        while (busy[0] && n < 200) begin
            step(1);
            n++;
        end
        chk("t6_busy_fell", int'(busy[0]), 0);
        send(0, 10'h3C0, 1'b1);
        chk("t6_restart", int'(cs_n[0]), 0);
        wait_done("t6_done");
        chk("t6_overrun_count", gi[0].ov_cnt - ov0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
